// File: rtl/adc_conv_sched_if.sv
// Signal bundle between the conversion scheduler and the parallel ADC / FIR bank.
// The master side is the scheduler; the slave side is the ADC, its data bus and the downstream consumer.
interface adc_conv_sched_if;
  logic        enable;
  logic [15:0] period;
  logic        busy;
  logic [15:0] adcdb;
  logic        conA;
  logic        conB;
  logic        conC;
  logic        adcrst;
  logic        adccs;
  logic        adcrd;
  logic [15:0] ch_data;
  logic [2:0]  ch_idx;
  logic        ch_valid;
  logic        frame_done;
  logic        overrun;
  logic        tmo_err;

  modport master (
    input  enable, period, busy, adcdb,
    output conA, conB, conC, adcrst, adccs, adcrd,
    output ch_data, ch_idx, ch_valid, frame_done, overrun, tmo_err
  );

  modport slave (
    output enable, period, busy, adcdb,
    input  conA, conB, conC, adcrst, adccs, adcrd,
    input  ch_data, ch_idx, ch_valid, frame_done, overrun, tmo_err
  );
endinterface

// File: rtl/adc_conv_sched.sv
// Conversion scheduler for the 6-channel parallel ADC: paced convert/busy/read sequencing,
// per-channel word output, frame strobe, busy-timeout recovery and overrun flag.
module adc_conv_sched #(
  parameter int NCH     = 6,
  parameter int RST_CYC = 20,
  parameter int CONV_LO = 4,
  parameter int RD_LO   = 3,
  parameter int RD_HI   = 2,
  parameter int TMO     = 4096
) (
  input logic               clk,
  input logic               rst,
  adc_conv_sched_if.master  bus
);

  typedef enum logic [2:0] {RST_S, IDLE, CONV, WBH, WBL, RDL, RDH} state_t;

  state_t      state;
  state_t      nstate;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [2:0]  ch;
  logic [2:0]  ch_nxt;
  logic [15:0] pcnt;
  logic [15:0] eff_q;
  logic [15:0] eff_in;
  logic        tick;
  logic        tmo_hit;
  logic        cap;
  logic        rst_d;
  logic        con_d;
  logic        cs_d;
  logic        rd_d;

  assign eff_in = (bus.period < 16'd64) ? 16'd64 : bus.period;
  assign tick   = bus.enable && (pcnt == eff_q - 16'd1);

  // Period pacing; the interval is latched at each wrap and tracks the input while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= 16'd0;
      eff_q <= 16'd64;
    end else if (!bus.enable || tick) begin
      pcnt  <= 16'd0;
      eff_q <= eff_in;
    end else begin
      pcnt  <= pcnt + 16'd1;
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RST_S;
      cnt            <= 16'd0;
      ch             <= 3'd0;
      bus.adcrst     <= 1'b1;
      bus.conA       <= 1'b1;
      bus.conB       <= 1'b1;
      bus.conC       <= 1'b1;
      bus.adccs      <= 1'b1;
      bus.adcrd      <= 1'b1;
      bus.ch_data    <= 16'd0;
      bus.ch_idx     <= 3'd0;
      bus.ch_valid   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.tmo_err    <= 1'b0;
    end else begin
      state          <= nstate;
      cnt            <= cnt_nxt;
      ch             <= ch_nxt;
      bus.adcrst     <= rst_d;
      bus.conA       <= con_d;
      bus.conB       <= con_d;
      bus.conC       <= con_d;
      bus.adccs      <= cs_d;
      bus.adcrd      <= rd_d;
      bus.ch_valid   <= cap;
      bus.frame_done <= cap && (ch == 3'(NCH - 1));
      bus.tmo_err    <= tmo_hit;
      if (tick && (state != IDLE))
        bus.overrun  <= 1'b1;
      if (cap) begin
        bus.ch_data  <= bus.adcdb;
        bus.ch_idx   <= ch;
      end
    end
  end

  // Next-state logic; cnt doubles as the busy timeout counter in WBH/WBL
  always_comb begin
    nstate  = state;
    cnt_nxt = cnt + 16'd1;
    ch_nxt  = ch;
    tmo_hit = 1'b0;
    cap     = 1'b0;
    case (state)
      RST_S: begin
        if (cnt == 16'(RST_CYC - 1)) begin
          nstate  = IDLE;
          cnt_nxt = 16'd0;
        end
      end
      IDLE: begin
        cnt_nxt = 16'd0;
        if (tick)
          nstate = CONV;
      end
      CONV: begin
        if (cnt == 16'(CONV_LO - 1)) begin
          nstate  = WBH;
          cnt_nxt = 16'd0;
        end
      end
      WBH: begin
        if (bus.busy) begin
          nstate  = WBL;
          cnt_nxt = 16'd0;
        end else if (cnt == 16'(TMO - 1)) begin
          nstate  = RST_S;
          cnt_nxt = 16'd0;
          tmo_hit = 1'b1;
        end
      end
      WBL: begin
        if (!bus.busy) begin
          nstate  = RDL;
          cnt_nxt = 16'd0;
          ch_nxt  = 3'd0;
        end else if (cnt == 16'(TMO - 1)) begin
          nstate  = RST_S;
          cnt_nxt = 16'd0;
          tmo_hit = 1'b1;
        end
      end
      RDL: begin
        if (cnt == 16'(RD_LO - 1)) begin
          nstate  = RDH;
          cnt_nxt = 16'd0;
          cap     = 1'b1;
        end
      end
      RDH: begin
        if (cnt == 16'(RD_HI - 1)) begin
          cnt_nxt = 16'd0;
          if (ch == 3'(NCH - 1)) begin
            nstate = IDLE;
          end else begin
            nstate = RDL;
            ch_nxt = ch + 3'd1;
          end
        end
      end
      default: begin
        nstate  = RST_S;
        cnt_nxt = 16'd0;
      end
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state
  always_comb begin
    rst_d = (nstate == RST_S);
    con_d = (nstate != CONV);
    cs_d  = !((nstate == RDL) || (nstate == RDH));
    rd_d  = (nstate != RDL);
  end

endmodule
